fpu_short_arbiter: RTL

//  Shares one non-pipelined fpu_short unit between NREQ requesters (e.g. integer core FP path, load/convert helper).

---
 rtl/fpu_short_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fpu_short_arbiter.sv
// fpu_short_arbiter: round-robin share of one non-pipelined fpu_short unit
// between NREQ requesters. One op in flight; operands held in registers for
// the unit, result held on resp_data until the owning requester takes it.
// Optional watchdog on the BUSY wait: define FPU_ARB_TIMEOUT_EN.

// Per-requester slice: handshake qualifiers and operand packing.
module fpu_arb_lane (
  input  logic        accept,
  input  logic        owner,
  input  logic        in_resp,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [4:0]  funct5,
  input  logic [2:0]  rm,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [71:0] op
);
  assign req_ready  = accept;
  assign resp_valid = owner & in_resp;
  assign op         = {x, y, funct5, rm};
endmodule

module fpu_short_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_x,
  input  logic [32*NREQ-1:0]  req_y,
  input  logic [5*NREQ-1:0]   req_funct5,
  input  logic [3*NREQ-1:0]   req_rm,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [31:0]         resp_data,
  output logic                fpu_en,
  output logic [31:0]         fpu_x,
  output logic [31:0]         fpu_y,
  output logic [4:0]          fpu_funct5,
  output logic [2:0]          fpu_rm,
  input  logic [31:0]         fpu_res,
  input  logic                fpu_valid,
  output logic                err_timeout
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] QNAN = 32'h7fc00000;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  funct5;
    logic [2:0]  rm;
  } fpu_req_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         last_grant, grant_nxt;
  logic                  found, accept, in_resp;
  logic                  busy_done, timeout_hit;
  logic [31:0]           busy_res;
  int                    rr_idx;
  fpu_req_t [NREQ-1:0]   req_vec;

  assign accept  = (state == S_IDLE) && found;
  assign in_resp = (state == S_RESP);

  // last_grant doubles as the owner of the op in flight / result held
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fpu_arb_lane u_lane (
      .accept     (accept && (grant_nxt == GW'(i))),
      .owner      (last_grant == GW'(i)),
      .in_resp    (in_resp),
      .x          (req_x[32*i +: 32]),
      .y          (req_y[32*i +: 32]),
      .funct5     (req_funct5[5*i +: 5]),
      .rm         (req_rm[3*i +: 3]),
      .req_ready  (req_ready[i]),
      .resp_valid (resp_valid[i]),
      .op         (req_vec[i])
    );
  end

  // Round-robin pick: first valid requester after last_grant, wrapping
  always_comb begin
    found     = 1'b0;
    grant_nxt = last_grant;
    rr_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[GW'(rr_idx)]) begin
        found     = 1'b1;
        grant_nxt = GW'(rr_idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state; fpu_valid outside BUSY is stale and dropped
  always_comb begin
    state_nxt = state;
    busy_done = 1'b0;
    busy_res  = fpu_res;
    case (state)
      S_IDLE: if (found) state_nxt = S_BUSY;
      S_BUSY: begin
        if (fpu_valid) begin
          busy_done = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout_hit) begin
          busy_done = 1'b1;
          busy_res  = QNAN;
          state_nxt = S_RESP;
        end
      end
      S_RESP: if (|(resp_ready & resp_valid)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at accept, start pulse, result hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GW'(NREQ - 1);
      fpu_en     <= 1'b0;
      fpu_x      <= '0;
      fpu_y      <= '0;
      fpu_funct5 <= '0;
      fpu_rm     <= '0;
      resp_data  <= '0;
    end else begin
      fpu_en <= 1'b0;
      if (accept) begin
        last_grant <= grant_nxt;
        fpu_en     <= 1'b1;
        {fpu_x, fpu_y, fpu_funct5, fpu_rm} <= req_vec[grant_nxt];
      end
      if (busy_done) resp_data <= busy_res;
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  assign timeout_hit = (state == S_BUSY) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  // Watchdog: counts BUSY cycles without a result; a result in the expiry cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) tmo_cnt <= '0;
      else if (state == S_BUSY && !fpu_valid) begin
        tmo_cnt <= tmo_cnt + CW'(1);
        err_q   <= timeout_hit;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
